alu_uart_tx: RTL and testbench
==============================

Name: alu_uart_tx

Overview:
Downstream output stage for MiniAlu.
- Accepts 8-bit result bytes written by the ALU on a one-cycle strobe.
- Buffers them in a small FIFO.
- Serialises each byte as 8N1 UART frames on a single TX pin, so ALU results reach a host terminal alongside the LED bank.
- Sits between the MiniAlu result register and the board UART pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2.
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.
CNT_W, 9, width of the bit-period counter; must satisfy 2**CNT_W >= CLKS_PER_BIT.

Ports:
Clock  in  1  single system clock; all state updates on rising edge.
Reset  in  1  asynchronous, active-low reset (Reset = 0 resets the block).
iData  in  8  byte to transmit, sampled when iWrite = 1.
iWrite  in  1  write strobe; one byte per cycle it is high.
oFull  out  1  FIFO holds FIFO_DEPTH entries.
oBusy  out  1  frame in progress or FIFO not empty.
oOverflow  out  1  sticky; set when a write is dropped.
oTx  out  1  serial line, idle high.

Behaviour:
- Reset (async, while Reset = 0):
  - oTx = 1, oFull = 0, oBusy = 0, oOverflow = 0.
  - FIFO pointers/count = 0, FSM = IDLE, bit counter and bit index = 0.
  - Reset mid-frame aborts the frame; oTx returns high immediately, without waiting for an edge.
- FIFO:
  - Count register of width log2(FIFO_DEPTH)+1.
  - oFull = (count == FIFO_DEPTH), decoded from registers.
  - Write accepted when iWrite = 1 and oFull = 0 at the sampling edge.
  - Write with oFull = 1 is dropped and sets oOverflow, even if a pop occurs the same cycle. oOverflow clears only on Reset.
  - Simultaneous accepted write and pop leave the count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: oTx = 1. If count != 0, pop the head into an 8-bit shift register and go to START; bit counter = 0.
  - START: oTx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: oTx = shift[0], LSB first. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: oTx = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- oTx is driven from a register; no combinational glitches.
- Latency: a write into an empty FIFO with FSM in IDLE is accepted at edge N. The pop happens at edge N+1, and oTx falls at edge N+2.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are separated by exactly 1 IDLE cycle (oTx high).
- Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- oBusy = (FSM != IDLE) | (count != 0), registered-equivalent.
  - oBusy goes low in the IDLE cycle after the last STOP, provided the FIFO is empty.
- Writes are accepted in any FSM state; frame timing is never disturbed by writes.

Optional Feature:
Macro: ALU_UART_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - oTx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
- Undefined:
  - No PARITY state, no parity logic; 8N1 frame as above.

Test Plan:
1. CLKS_PER_BIT = 4. Reset low for 3 cycles, then high. Write 0xA5 once.
   -> oTx falls 2 edges after write. Each level is held 4 cycles, in sequence 0 | 1,0,1,0,0,1,0,1 | 1. oBusy high for 41 cycles total (1 pop cycle + 40 frame cycles), then low.
2. Write 0x01, 0x80, 0xFF on consecutive cycles.
   -> Three frames in order with data bits 10000000, 00000001, 11111111 (LSB first). Exactly 1 idle-high cycle between frames. oOverflow stays 0.
3. FIFO_DEPTH = 4, CLKS_PER_BIT = 4. Write 6 bytes 0x10..0x15 on consecutive cycles.
   -> oFull asserts. One write is dropped and oOverflow = 1 (sticky). Transmitted bytes are 0x10..0x14, with 0x15 missing.
4. Pull Reset low mid-DATA of 0x3C.
   -> oTx = 1 immediately, and oFull, oBusy, oOverflow = 0. After release, no residual frame is sent. A new write of 0x55 transmits normally.
5. With oFull = 1, assert iWrite in the same cycle the FSM pops.
   -> Count decrements by 1, the write is dropped, and oOverflow = 1.
6. ALU_UART_PARITY_EN defined. Write 0x07.
   -> Frame is 0 | 1,1,1,0,0,0,0,0 | parity 1 | 1, lasting 44 cycles. Write 0xA5 -> parity bit 0.

Source files
------------

// File: rtl/alu_uart_tx.sv
// alu_uart_tx: output stage that buffers MiniAlu result bytes in a small FIFO
// and sends each one as an 8N1 UART frame on oTx (idle high, LSB first).
// Optional feature: define ALU_UART_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit (8E1, 11 bit periods per frame).
module alu_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 9
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iWrite,
  output logic       oFull,
  output logic       oBusy,
  output logic       oOverflow,
  output logic       oTx
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef ALU_UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             ovf_q;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic             push, pop;
`ifdef ALU_UART_PARITY_EN
  logic             par_q;
`endif

  // Full is decoded from the registered count, so a pop in the same cycle
  // never rescues a write that arrives while full.
  assign oFull     = (count_q == DEPTH_C);
  assign oBusy     = (state_q != S_IDLE) | (count_q != '0);
  assign oOverflow = ovf_q;
  assign oTx       = tx_q;
  assign push      = iWrite & ~oFull;

  // FIFO occupancy: accepted write and pop in one cycle cancel out
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control state: pointers wrap naturally at the power-of-two depth
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (iWrite && oFull) ovf_q <= 1'b1;
    end
  end

  // FIFO storage needs no reset; entries are only read once written
  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= iData;
  end

  // Frame sequencer; tx_d is the line level for the current state and is
  // registered, so oTx trails the state by one cycle and is glitch-free
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
`ifdef ALU_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef ALU_UART_PARITY_EN
      S_PARITY: begin
        tx_d = par_q;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Sequencer control registers; reset forces the line high at once
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  // Data shift register is only meaningful after a pop, so it is not reset
  always_ff @(posedge Clock) begin
    shift_q <= shift_d;
  end

`ifdef ALU_UART_PARITY_EN
  // Even parity of the byte, captured as it leaves the FIFO
  always_ff @(posedge Clock) begin
    if (pop) par_q <= ^mem_q[rd_ptr_q];
  end
`endif

endmodule

// File: tb/tb_alu_uart_tx.sv
// Bench for alu_uart_tx: directed writes, a UART receiver that decodes oTx
// and checks each frame against a queue of expected bytes.
module tb_alu_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef ALU_UART_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       iWrite = 1'b0;
  logic       oFull, oBusy, oOverflow, oTx;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         cyc = 0;

  alu_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .Clock(Clock), .Reset(Reset), .iData(iData), .iWrite(iWrite),
    .oFull(oFull), .oBusy(oBusy), .oOverflow(oOverflow), .oTx(oTx)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    iData  = b;
    iWrite = 1'b1;
    tick();
    iWrite = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (oBusy && k < bound) begin
      tick();
      k++;
    end
    check("idle_timeout", oBusy, 1'b0);
    tick();
    tick();
  endtask

  // UART receiver: samples mid-cycle, checks every sample of every bit
  logic       mon_active = 1'b0;
  logic       prev_tx = 1'b1;
  int         mon_pos = 0;
  logic [7:0] mon_byte = 8'h00;
  always @(negedge Clock) begin
    int bi;
    cyc++;
    if (!Reset) begin
      mon_active = 1'b0;
      prev_tx    = 1'b1;
    end else begin
      if (!mon_active && prev_tx === 1'b1 && oTx === 1'b0) begin
        mon_active = 1'b1;
        mon_pos    = 0;
        mon_byte   = 8'h00;
        start_q.push_back(cyc);
      end else if (mon_active) begin
        mon_pos++;
      end
      if (mon_active) begin
        if (mon_pos < CPB) begin
          check("start_bit", oTx, 1'b0);
        end else if (mon_pos < 9 * CPB) begin
          bi = (mon_pos - CPB) / CPB;
          if ((mon_pos - CPB) % CPB == 0) mon_byte[bi] = oTx;
          else check("data_hold", oTx, mon_byte[bi]);
`ifdef ALU_UART_PARITY_EN
        end else if (mon_pos < 10 * CPB) begin
          check("parity_bit", oTx, ^mon_byte);
`endif
        end else begin
          check("stop_bit", oTx, 1'b1);
        end
        if (mon_pos == FRAME - 1) begin
          mon_active = 1'b0;
          check("frame_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) check("rx_byte", mon_byte, exp_q.pop_front());
        end
      end
      prev_tx = oTx;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int n;

    // Reset state
    Reset = 1'b0;
    repeat (3) tick();
    check("rst_tx", oTx, 1'b1);
    check("rst_full", oFull, 1'b0);
    check("rst_busy", oBusy, 1'b0);
    check("rst_ovf", oOverflow, 1'b0);
    Reset = 1'b1;
    tick();

    // Single byte: latency, busy duration, frame content
    exp_q.push_back(8'hA5);
    wr(8'hA5);
    check("t1_busy_after_write", oBusy, 1'b1);
    check("t1_tx_n", oTx, 1'b1);
    tick();
    check("t1_tx_n1", oTx, 1'b1);
    tick();
    check("t1_tx_fall_n2", oTx, 1'b0);
    busy_cnt = 3;
    while (oBusy && busy_cnt < 200) begin
      tick();
      if (oBusy) busy_cnt++;
    end
    check("t1_busy_cycles", busy_cnt, FRAME + 1);
    tick();
    tick();
    check("t1_queue_empty", exp_q.size(), 0);

    // Back-to-back frames with one idle cycle between them
    start_q.delete();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hFF);
    wr(8'h01);
    wr(8'h80);
    wr(8'hFF);
    wait_idle(400);
    check("t2_frames", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("t2_gap01", start_q[1] - start_q[0], FRAME + 1);
      check("t2_gap12", start_q[2] - start_q[1], FRAME + 1);
    end
    check("t2_ovf", oOverflow, 1'b0);
    check("t2_queue_empty", exp_q.size(), 0);

    // Overfill: six writes, the last one dropped
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
    check("t3_full", oFull, 1'b1);
    check("t3_ovf_before", oOverflow, 1'b0);
    wr(8'h15);
    check("t3_ovf_set", oOverflow, 1'b1);
    check("t3_still_full", oFull, 1'b1);
    wait_idle(600);
    check("t3_ovf_sticky", oOverflow, 1'b1);
    check("t3_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a frame
    wr(8'h3C);
    repeat (7) tick();
    check("t4_tx_bit0", oTx, 1'b0);
    check("t4_busy_mid", oBusy, 1'b1);
    Reset = 1'b0;
    #1;
    check("t4_rst_tx", oTx, 1'b1);
    check("t4_rst_full", oFull, 1'b0);
    check("t4_rst_busy", oBusy, 1'b0);
    check("t4_rst_ovf", oOverflow, 1'b0);
    repeat (2) tick();
    Reset = 1'b1;
    n = start_q.size();
    repeat (FRAME + 10) tick();
    check("t4_no_residual", start_q.size(), n);
    check("t4_tx_idle", oTx, 1'b1);
    exp_q.push_back(8'h55);
    wr(8'h55);
    wait_idle(200);
    check("t4_queue_empty", exp_q.size(), 0);

    // Write while full on the very cycle the FSM pops
    for (int i = 0; i < 5; i++) exp_q.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 5; i++) wr(8'hA0 + 8'(i));
    check("t5_full", oFull, 1'b1);
    repeat (FRAME - 3) tick();
    check("t5_full_pre_pop", oFull, 1'b1);
    check("t5_ovf_pre_pop", oOverflow, 1'b0);
    iData  = 8'hEE;
    iWrite = 1'b1;
    tick();
    iWrite = 1'b0;
    check("t5_full_after_pop", oFull, 1'b0);
    check("t5_ovf_set", oOverflow, 1'b1);
    wait_idle(1000);
    check("t5_queue_empty", exp_q.size(), 0);

`ifdef ALU_UART_PARITY_EN
    // Parity frames: odd and even number of ones
    exp_q.push_back(8'h07);
    wr(8'h07);
    busy_cnt = 1;
    while (oBusy && busy_cnt < 200) begin
      tick();
      if (oBusy) busy_cnt++;
    end
    check("t6_busy_cycles", busy_cnt, FRAME + 1);
    tick();
    tick();
    exp_q.push_back(8'hA5);
    wr(8'hA5);
    wait_idle(200);
    check("t6_queue_empty", exp_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
